vga_scan_engine: RTL



---
 rtl/vga_pkg.sv | 38 +++
 rtl/vga_axis_counter.sv | 51 +++++
 rtl/vga_scan_engine.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA scan engine.
package vga_pkg;

    typedef enum logic [1:0] {
        ACTIVE,
        FRONT,
        SYNC,
        BACK
    } scan_state_t;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    // One pixel's worth of timing flags travelling alongside the RAM read.
    typedef struct packed {
        logic       stb;
        logic       hs;
        logic       vs;
        logic       vid;
        logic       fs;
`ifdef VGA_TEST_PATTERN_EN
        logic [2:0] bar;
`endif
    } pipe_t;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter plus ACTIVE/FRONT/SYNC/BACK decode.
module vga_axis_counter
    import vga_pkg::scan_state_t;
#(
    parameter int unsigned ACTIVE = 640,
    parameter int unsigned FP     = 16,
    parameter int unsigned SYNC_W = 96,
    parameter int unsigned BP     = 48,
    parameter int unsigned CNT_W  = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output scan_state_t      state,
    output logic             wrap
);

    localparam int unsigned TOTAL = ACTIVE + FP + SYNC_W + BP;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        wrap  = inc && (cnt_q == CNT_W'(TOTAL - 1));
        cnt_d = cnt_q;
        if (inc) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end

        if (cnt_q < CNT_W'(ACTIVE)) begin
            state = vga_pkg::ACTIVE;
        end else if (cnt_q < CNT_W'(ACTIVE + FP)) begin
            state = vga_pkg::FRONT;
        end else if (cnt_q < CNT_W'(ACTIVE + FP + SYNC_W)) begin
            state = vga_pkg::SYNC;
        end else begin
            state = vga_pkg::BACK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/vga_scan_engine.sv
// VGA timing, framebuffer fetch and RGB332 expansion with syncs aligned to pixel data.
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN.
module vga_scan_engine
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
    parameter int unsigned H_FP        = VGA_H_FP,
    parameter int unsigned H_SYNC      = VGA_H_SYNC,
    parameter int unsigned H_BP        = VGA_H_BP,
    parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
    parameter int unsigned V_FP        = VGA_V_FP,
    parameter int unsigned V_SYNC      = VGA_V_SYNC,
    parameter int unsigned V_BP        = VGA_V_BP,
    parameter logic        SYNC_POL    = 1'b0,
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned SCALE_SHIFT = 0,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned ADDR_W      = 19
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [7:0]        fb_data,
`ifdef VGA_TEST_PATTERN_EN
    input  logic              test_mode,
`endif
    output logic              hsync,
    output logic              vsync,
    output logic              vgaclk,
    output logic [7:0]        Red,
    output logic [7:0]        Green,
    output logic [7:0]        Blue,
    output logic              frame_start,
    output logic [10:0]       pix_x,
    output logic [9:0]        pix_y
);

    localparam int unsigned DEPTH = RD_LAT + 1;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0]  div_q, div_d;
    logic              pix_en;
    logic              vgaclk_q, vgaclk_d;
    logic [10:0]       h_cnt;
    logic [9:0]        v_cnt;
    scan_state_t       h_state, v_state;
    logic              h_wrap, v_wrap_unused;
    logic              video_on;
    logic [31:0]       addr_full;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    pipe_t             pipe_q [DEPTH];
    pipe_t             stage_d, mature;
    rgb332_t           px;
    logic              hsync_q, hsync_d, vsync_q, vsync_d;
    logic              frame_start_q, frame_start_d;
    logic [7:0]        red_q, red_d, green_q, green_d, blue_q, blue_d;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC_W(H_SYNC), .BP(H_BP), .CNT_W(11)
    ) u_h_axis (
        .clk(clk), .rst(rst), .inc(pix_en),
        .cnt(h_cnt), .state(h_state), .wrap(h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC_W(V_SYNC), .BP(V_BP), .CNT_W(10)
    ) u_v_axis (
        .clk(clk), .rst(rst), .inc(h_wrap),
        .cnt(v_cnt), .state(v_state), .wrap(v_wrap_unused)
    );

    always_comb begin
        pix_en   = (div_q == DIV_W'(CLK_DIV - 1));
        div_d    = pix_en ? '0 : div_q + 1'b1;
        vgaclk_d = (CLK_DIV == 1) ? 1'b1 : (div_d >= DIV_W'(CLK_DIV / 2));

        video_on  = (h_state == ACTIVE) && (v_state == ACTIVE);
        addr_full = 32'(v_cnt >> SCALE_SHIFT) * 32'(H_ACTIVE >> SCALE_SHIFT)
                  + 32'(h_cnt >> SCALE_SHIFT);
        fb_addr_d = (pix_en && video_on) ? ADDR_W'(addr_full) : fb_addr_q;

        stage_d     = '0;
        stage_d.stb = pix_en;
        stage_d.hs  = (h_state == SYNC);
        stage_d.vs  = (v_state == SYNC);
        stage_d.vid = video_on;
        stage_d.fs  = (h_cnt == '0) && (v_cnt == '0);
`ifdef VGA_TEST_PATTERN_EN
        stage_d.bar = 3'((32'(h_cnt) * 32'd8) / H_ACTIVE);
`endif

        mature        = pipe_q[DEPTH-1];
        px            = rgb332_t'(fb_data);
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        red_d         = red_q;
        green_d       = green_q;
        blue_d        = blue_q;
        frame_start_d = mature.stb && mature.fs;
        if (mature.stb) begin
            hsync_d = mature.hs ? SYNC_POL : ~SYNC_POL;
            vsync_d = mature.vs ? SYNC_POL : ~SYNC_POL;
            if (!mature.vid) begin
                red_d   = '0;
                green_d = '0;
                blue_d  = '0;
            end
`ifdef VGA_TEST_PATTERN_EN
            else if (test_mode) begin
                red_d   = {8{mature.bar[2]}};
                green_d = {8{mature.bar[1]}};
                blue_d  = {8{mature.bar[0]}};
            end
`endif
            else begin
                red_d   = {px.r, px.r, px.r[2:1]};
                green_d = {px.g, px.g, px.g[2:1]};
                blue_d  = {4{px.b}};
            end
        end
    end

    // The flag line shifts every clk, so it serves both one-pixel-in-flight and
    // overlapped (RD_LAT+1 > CLK_DIV) configurations without a separate path.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= '0;
            vgaclk_q      <= 1'b0;
            fb_addr_q     <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            frame_start_q <= 1'b0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            div_q         <= div_d;
            vgaclk_q      <= vgaclk_d;
            fb_addr_q     <= fb_addr_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            pipe_q[0]     <= stage_d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign fb_addr     = fb_addr_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign vgaclk      = vgaclk_q;
    assign Red         = red_q;
    assign Green       = green_q;
    assign Blue        = blue_q;
    assign frame_start = frame_start_q;
    assign pix_x       = h_cnt;
    assign pix_y       = v_cnt;

endmodule
